// File: rtl/bet_checker_if.sv
// Bet-entry to bet-checker bus: draw load, bet line presentation and scoring results.
interface bet_checker_if #(
  parameter int W = 5
);
  logic         draw_valid;
  logic [W-1:0] D_in;
  logic         Set;
  logic         V;
  logic [W-1:0] B1;
  logic [W-1:0] B2;
  logic [W-1:0] B3;
  logic [W-1:0] B4;
  logic [1:0]   number;
  logic         finish;
  logic         res_valid;
  logic [2:0]   hits;
  logic [1:0]   prize;
  logic [1:0]   line_idx;
  logic [2:0]   total_win;
  logic         done;
  logic         DRW_ERR;
  logic         OVR_ERR;

  modport master (
    output draw_valid, D_in, Set, V, B1, B2, B3, B4, number, finish,
    input  res_valid, hits, prize, line_idx, total_win, done, DRW_ERR, OVR_ERR
  );

  modport slave (
    input  draw_valid, D_in, Set, V, B1, B2, B3, B4, number, finish,
    output res_valid, hits, prize, line_idx, total_win, done, DRW_ERR, OVR_ERR
  );
endinterface

// File: rtl/bet_checker.sv
// Loads four drawn numbers, scores each presented bet line one number per cycle,
// and tallies winning lines until the entry block reports finish.
//
// state | meaning
// IDLE  | no draw seen yet
// LOAD  | collecting the four distinct drawn numbers
// WAIT  | draw loaded, waiting for a Set or finish edge
// CMP   | comparing B1..B4 against the draw, one per cycle
// DONE  | tally final, held until reset
module bet_checker #(
  parameter int W        = 5,
  parameter int MAX_NUM  = 31,
  parameter int MIN_HITS = 2,
  parameter int SYNC     = 2
) (
  input  logic        clk,
  input  logic        reset,
  bet_checker_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CMP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      di_q, di_d;
  logic [W-1:0]    draw_q [4];
  logic [W-1:0]    draw_d [4];
  logic [W-1:0]    b_q [4];
  logic [W-1:0]    b_d [4];
  logic [1:0]      idx_q, idx_d;
  logic            v_q, v_d;
  logic [1:0]      k_q, k_d;
  logic [2:0]      acc_q, acc_d;
  logic            fin_pend_q, fin_pend_d;
  logic [SYNC-1:0] set_sync_q, set_sync_d;
  logic [SYNC-1:0] fin_sync_q, fin_sync_d;
  logic            set_prev_q, set_prev_d;
  logic            fin_prev_q, fin_prev_d;
  logic            res_valid_q, res_valid_d;
  logic [2:0]      hits_q, hits_d;
  logic [1:0]      prize_q, prize_d;
  logic [1:0]      line_idx_q, line_idx_d;
  logic [2:0]      total_q, total_d;
  logic            drw_err_q, drw_err_d;
  logic            ovr_err_q, ovr_err_d;

  logic            set_edge, fin_edge;
  logic            draw_bad, dup, hit;
  logic [W-1:0]    cur_b;
  logic [2:0]      acc_sum;

  function automatic logic [1:0] prize_of(input logic [2:0] h);
    int p;
    if (int'(h) >= MIN_HITS) begin
      p = int'(h) - MIN_HITS + 1;
      if (p > 3) p = 3;
      return 2'(p);
    end
    return 2'd0;
  endfunction

  assign set_edge = set_sync_q[SYNC-1] & ~set_prev_q;
  assign fin_edge = fin_sync_q[SYNC-1] & ~fin_prev_q;

  // Duplicate check only covers draws already accepted.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(di_q) && draw_q[i] == bus.D_in) dup = 1'b1;
    end
    draw_bad = (bus.D_in == '0) || (int'(bus.D_in) > MAX_NUM) || dup;
  end

  assign cur_b   = b_q[k_q];
  assign hit     = v_q && ((cur_b == draw_q[0]) || (cur_b == draw_q[1]) ||
                           (cur_b == draw_q[2]) || (cur_b == draw_q[3]));
  assign acc_sum = acc_q + {2'b00, hit};

  always_comb begin
    state_d     = state_q;
    di_d        = di_q;
    draw_d      = draw_q;
    b_d         = b_q;
    idx_d       = idx_q;
    v_d         = v_q;
    k_d         = k_q;
    acc_d       = acc_q;
    fin_pend_d  = fin_pend_q;
    res_valid_d = 1'b0;
    hits_d      = hits_q;
    prize_d     = prize_q;
    line_idx_d  = line_idx_q;
    total_d     = total_q;
    drw_err_d   = drw_err_q;
    ovr_err_d   = ovr_err_q;
    set_sync_d  = {set_sync_q[SYNC-2:0], bus.Set};
    fin_sync_d  = {fin_sync_q[SYNC-2:0], bus.finish};
    set_prev_d  = set_sync_q[SYNC-1];
    fin_prev_d  = fin_sync_q[SYNC-1];

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (set_edge) ovr_err_d = 1'b1;
        if (bus.draw_valid) begin
          if (state_q == S_IDLE) state_d = S_LOAD;
          if (draw_bad) begin
            drw_err_d = 1'b1;
          end else begin
            draw_d[di_q] = bus.D_in;
            di_d         = di_q + 2'd1;
            if (di_q == 2'd3) state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (set_edge) begin
          b_d     = '{bus.B1, bus.B2, bus.B3, bus.B4};
          idx_d   = bus.number;
          v_d     = bus.V;
          acc_d   = 3'd0;
          k_d     = 2'd0;
          state_d = S_CMP;
          // A simultaneous finish is honoured only after this line is scored.
          if (fin_edge) fin_pend_d = 1'b1;
        end else if (fin_edge) begin
          state_d = S_DONE;
        end
      end
      S_CMP: begin
        if (set_edge) ovr_err_d = 1'b1;
        if (fin_edge) fin_pend_d = 1'b1;
        acc_d = acc_sum;
        k_d   = k_q + 2'd1;
        if (k_q == 2'd3) begin
          res_valid_d = 1'b1;
          hits_d      = acc_sum;
          prize_d     = prize_of(acc_sum);
          line_idx_d  = idx_q;
          if (prize_d != 2'd0 && total_q != 3'd7) total_d = total_q + 3'd1;
          state_d     = (fin_pend_q || fin_edge) ? S_DONE : S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      di_q        <= 2'd0;
      draw_q      <= '{default: '0};
      b_q         <= '{default: '0};
      idx_q       <= 2'd0;
      v_q         <= 1'b0;
      k_q         <= 2'd0;
      acc_q       <= 3'd0;
      fin_pend_q  <= 1'b0;
      set_sync_q  <= '0;
      fin_sync_q  <= '0;
      set_prev_q  <= 1'b0;
      fin_prev_q  <= 1'b0;
      res_valid_q <= 1'b0;
      hits_q      <= 3'd0;
      prize_q     <= 2'd0;
      line_idx_q  <= 2'd0;
      total_q     <= 3'd0;
      drw_err_q   <= 1'b0;
      ovr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      di_q        <= di_d;
      draw_q      <= draw_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      v_q         <= v_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      fin_pend_q  <= fin_pend_d;
      set_sync_q  <= set_sync_d;
      fin_sync_q  <= fin_sync_d;
      set_prev_q  <= set_prev_d;
      fin_prev_q  <= fin_prev_d;
      res_valid_q <= res_valid_d;
      hits_q      <= hits_d;
      prize_q     <= prize_d;
      line_idx_q  <= line_idx_d;
      total_q     <= total_d;
      drw_err_q   <= drw_err_d;
      ovr_err_q   <= ovr_err_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.hits      = hits_q;
  assign bus.prize     = prize_q;
  assign bus.line_idx  = line_idx_q;
  assign bus.total_win = total_q;
  assign bus.done      = (state_q == S_DONE);
  assign bus.DRW_ERR   = drw_err_q;
  assign bus.OVR_ERR   = ovr_err_q;

endmodule

// File: tb/tb_bet_checker.sv
// Directed bench for bet_checker: draw loading, line scoring latency/values,
// overlap and draw errors, finish handling, tally saturation and mid-compare reset.
module tb_bet_checker;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   rv_cnt;
  int   m_total;
  int   m_ovr;
  int   m_drw;
  int   m_n;
  logic [4:0] m_draw [4];
  logic [6:0] sb [$];

  bet_checker_if #(.W(5)) bus ();

  bet_checker #(.W(5), .MAX_NUM(31), .MIN_HITS(2), .SYNC(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.res_valid === 1'b1) rv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.Set = 1'b0; bus.finish = 1'b0; bus.draw_valid = 1'b0;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    m_total = 0; m_ovr = 0; m_drw = 0; m_n = 0;
    m_draw = '{default: '0};
    sb.delete();
  endtask

  task automatic do_draw(input logic [4:0] val);
    bit bad;
    tick(1);
    bus.draw_valid = 1'b1; bus.D_in = val;
    tick(1);
    bus.draw_valid = 1'b0;
    if (m_n < 4) begin
      bad = (val == 5'd0);
      for (int i = 0; i < m_n; i++) if (m_draw[i] == val) bad = 1'b1;
      if (bad) m_drw = 1;
      else begin m_draw[m_n] = val; m_n++; end
    end
    chk("drw_err", bus.DRW_ERR, m_drw);
  endtask

  task automatic score_line(input logic [4:0] b1, input logic [4:0] b2, input logic [4:0] b3,
                            input logic [4:0] b4, input logic v, input logic [1:0] idx,
                            input bit glitch, input bit with_fin, input string tag);
    logic [4:0] bl [4];
    int eh, ep, lat;
    bit got;
    logic [6:0] e;
    bl = '{b1, b2, b3, b4};
    eh = 0;
    if (v) for (int i = 0; i < 4; i++) begin
      if (bl[i] == m_draw[0] || bl[i] == m_draw[1] || bl[i] == m_draw[2] || bl[i] == m_draw[3])
        eh++;
    end
    ep = (eh >= 2) ? ((eh - 1 > 3) ? 3 : eh - 1) : 0;
    sb.push_back({3'(eh), 2'(ep), idx});
    tick(1);
    bus.B1 = b1; bus.B2 = b2; bus.B3 = b3; bus.B4 = b4;
    bus.V = v; bus.number = idx; bus.Set = 1'b1;
    if (with_fin) bus.finish = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      tick(1);
      lat++;
      if (glitch && lat == 1) bus.Set = 1'b0;
      if (glitch && lat == 2) bus.Set = 1'b1;
      if (bus.res_valid === 1'b1) got = 1'b1;
    end
    chk({tag, ".seen"}, 32'(got), 1);
    chk({tag, ".latency"}, lat, 7);
    if (sb.size() > 0) e = sb.pop_front(); else e = '1;
    chk({tag, ".hits"}, bus.hits, e[6:4]);
    chk({tag, ".prize"}, bus.prize, e[3:2]);
    chk({tag, ".idx"}, bus.line_idx, e[1:0]);
    if (ep > 0 && m_total < 7) m_total++;
    chk({tag, ".total"}, bus.total_win, m_total);
    bus.Set = 1'b0;
    tick(1);
    chk({tag, ".pulse1"}, bus.res_valid, 0);
    tick(3);
    chk({tag, ".hold"}, bus.hits, e[6:4]);
  endtask

  initial begin
    int rv0, n;
    checks = 0; errors = 0; rv_cnt = 0;
    bus.draw_valid = 0; bus.D_in = 0; bus.Set = 0; bus.V = 0; bus.number = 0;
    bus.B1 = 0; bus.B2 = 0; bus.B3 = 0; bus.B4 = 0; bus.finish = 0;
    reset = 1'b1;
    tick(1);
    do_reset();

    // reset state
    chk("rst.res_valid", bus.res_valid, 0);
    chk("rst.hits", bus.hits, 0);
    chk("rst.prize", bus.prize, 0);
    chk("rst.total", bus.total_win, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.drw", bus.DRW_ERR, 0);
    chk("rst.ovr", bus.OVR_ERR, 0);

    // full match, then no match, then finish
    do_draw(5); do_draw(21); do_draw(24); do_draw(28);
    score_line(5, 21, 24, 28, 1, 0, 0, 0, "t1");
    score_line(1, 3, 22, 26, 1, 1, 0, 0, "t2");
    bus.finish = 1'b1;
    n = 0;
    while (bus.done !== 1'b1 && n < 10) begin tick(1); n++; end
    chk("t2.done", bus.done, 1);
    chk("t2.total", bus.total_win, 1);
    rv0 = rv_cnt;
    bus.Set = 1'b1;
    tick(12);
    chk("t2.set_in_done", rv_cnt, rv0);
    chk("t2.ovr", bus.OVR_ERR, 0);
    chk("t2.done_hold", bus.done, 1);

    // draw rejects, partial hits, invalid line, duplicate bet numbers
    do_reset();
    do_draw(5); do_draw(5);
    do_draw(0);
    do_draw(21); do_draw(24); do_draw(28);
    score_line(5, 21, 1, 2, 1, 2, 0, 0, "t4a");
    score_line(5, 21, 24, 9, 0, 3, 0, 0, "t4b");
    score_line(5, 21, 24, 1, 1, 1, 0, 0, "t4c");
    score_line(5, 5, 5, 21, 1, 0, 0, 0, "t4d");
    chk("t4.ovr", bus.OVR_ERR, 0);

    // second Set edge while comparing
    rv0 = rv_cnt;
    score_line(28, 24, 2, 3, 1, 2, 1, 0, "t5");
    tick(10);
    chk("t5.ovr", bus.OVR_ERR, 1);
    chk("t5.one_result", rv_cnt - rv0, 1);

    // Set and finish in the same cycle: scored, then done
    score_line(24, 28, 5, 30, 1, 3, 0, 1, "t5b");
    chk("t5b.done", bus.done, 1);
    bus.finish = 1'b0;

    // reset in the middle of a compare
    do_reset();
    do_draw(5); do_draw(21); do_draw(24); do_draw(28);
    tick(1);
    bus.B1 = 5; bus.B2 = 21; bus.B3 = 24; bus.B4 = 28; bus.V = 1; bus.number = 1;
    bus.Set = 1'b1;
    tick(4);
    rv0 = rv_cnt;
    reset = 1'b0;
    bus.Set = 1'b0;
    tick(1);
    chk("t6.res_valid", bus.res_valid, 0);
    chk("t6.hits", bus.hits, 0);
    chk("t6.prize", bus.prize, 0);
    chk("t6.total", bus.total_win, 0);
    chk("t6.done", bus.done, 0);
    reset = 1'b1;
    tick(10);
    chk("t6.no_result", rv_cnt, rv0);

    // reload and score; tally saturates at seven
    do_reset();
    do_draw(7); do_draw(31); do_draw(1); do_draw(16);
    for (int i = 0; i < 9; i++) begin
      score_line(7, 31, 1, 16, 1, 2'(i), 0, 0, "t6sat");
    end
    chk("t6.sat", bus.total_win, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
